pc_sequencer: RTL and testbench

//   Owns the program counter register and sequences instruction fetch for the 9-bit-instruction core.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_next_calc.sv | 28 ++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the 9-bit-instruction core.
// Holds the fetch sequencer state encoding and the branch-offset sign extension.
package cpu_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 9;
  localparam int OFF_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  function automatic logic [PC_W-1:0] sext_off(input logic [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-pc candidates for the fetch sequencer.
// Produces both the sequential and the branch target so the FSM only has to choose.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int PC_STEP   = 4,
  parameter int OFF_SHIFT = 2
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               branch,
  input  logic               zero,
  output logic [PC_W-1:0]    next_seq,
  output logic [PC_W-1:0]    target,
  output logic               take
);

  logic [PC_W-1:0] w_off_scaled;
  logic            w_unused;

  // Only the low bits carry the offset; the opcode bits are the decoder's business.
  assign w_unused     = ^instruction[INSTR_W-1:OFF_W];
  assign w_off_scaled = sext_off(instruction[OFF_W-1:0]) << OFF_SHIFT;
  assign next_seq     = pc + PC_W'(PC_STEP);
  assign target       = next_seq + w_off_scaled;
  assign take         = branch & zero;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: start, sequential advance, branches, stalls, halt.
// All outputs are registered; the retire/taken counters are cleared on every accepted start.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_STEP   = 4,
  parameter int OFF_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               branch,
  input  logic               zero,
  input  logic               halt_instr,
  input  logic               stall,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_en,
  output logic               done,
  output logic               branch_taken,
  output logic [PC_W-1:0]    instr_count,
  output logic [PC_W-1:0]    taken_count
);

  seq_state_t      r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_instr_count;
  logic [PC_W-1:0] r_taken_count;
  logic            r_fetch_en;
  logic            r_done;
  logic            r_branch_taken;

  logic [PC_W-1:0] w_next_seq;
  logic [PC_W-1:0] w_target;
  logic            w_take;

  pc_next_calc #(
    .PC_STEP   (PC_STEP),
    .OFF_SHIFT (OFF_SHIFT)
  ) u_next (
    .pc          (r_pc),
    .instruction (instruction),
    .branch      (branch),
    .zero        (zero),
    .next_seq    (w_next_seq),
    .target      (w_target),
    .take        (w_take)
  );

  // NOTE: all state here uses <= so every branch sees the pre-edge values of r_*.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_pc           <= '0;
      r_instr_count  <= '0;
      r_taken_count  <= '0;
      r_fetch_en     <= 1'b0;
      r_done         <= 1'b0;
      r_branch_taken <= 1'b0;
    end else begin
      r_branch_taken <= 1'b0;
      case (r_state)
        IDLE, HALT: begin
          if (start) begin
            r_state       <= RUN;
            r_pc          <= start_addr;
            r_instr_count <= '0;
            r_taken_count <= '0;
            r_fetch_en    <= 1'b1;
            r_done        <= 1'b0;
          end
        end
        RUN: begin
          if (stall) begin
            r_state    <= STALL;
            r_fetch_en <= 1'b0;
          end else if (halt_instr) begin
            // pc stays on the halt address so the host can see where it stopped
            r_state       <= HALT;
            r_instr_count <= r_instr_count + 1'b1;
            r_fetch_en    <= 1'b0;
            r_done        <= 1'b1;
          end else begin
            r_instr_count <= r_instr_count + 1'b1;
            if (w_take) begin
              r_pc           <= w_target;
              r_taken_count  <= r_taken_count + 1'b1;
              r_branch_taken <= 1'b1;
            end else begin
              r_pc <= w_next_seq;
            end
          end
        end
        STALL: begin
          // the stalled instruction is re-evaluated from scratch once back in RUN
          if (!stall) begin
            r_state    <= RUN;
            r_fetch_en <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_fetch_en <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign fetch_en     = r_fetch_en;
  assign done         = r_done;
  assign branch_taken = r_branch_taken;
  assign instr_count  = r_instr_count;
  assign taken_count  = r_taken_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives one cycle of inputs and
// compares every registered output against hand-computed values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] start_addr;
  logic [8:0]  instruction;
  logic        branch;
  logic        zero;
  logic        halt_instr;
  logic        stall;
  logic [31:0] pc;
  logic        fetch_en;
  logic        done;
  logic        branch_taken;
  logic [31:0] instr_count;
  logic [31:0] taken_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .instruction  (instruction),
    .branch       (branch),
    .zero         (zero),
    .halt_instr   (halt_instr),
    .stall        (stall),
    .pc           (pc),
    .fetch_en     (fetch_en),
    .done         (done),
    .branch_taken (branch_taken),
    .instr_count  (instr_count),
    .taken_count  (taken_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ic;
    logic [31:0] tc;
    logic        fe;
    logic        dn;
    logic        bt;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic [31:0] addr;
    logic [8:0]  ins;
    logic        br;
    logic        z;
    logic        h;
    logic        s;
    out_t        exp;
  } vec_t;

  function automatic out_t observed();
    return '{pc: pc, ic: instr_count, tc: taken_count,
             fe: fetch_en, dn: done, bt: branch_taken};
  endfunction

  function automatic out_t ex(input logic [31:0] p, input logic [31:0] ic,
                              input logic [31:0] tc, input logic fe,
                              input logic dn, input logic bt);
    return '{pc: p, ic: ic, tc: tc, fe: fe, dn: dn, bt: bt};
  endfunction

  function automatic vec_t v(input logic rst, input logic st, input logic [31:0] addr,
                             input logic [8:0] ins, input logic br, input logic z,
                             input logic h, input logic s, input out_t e);
    return '{rst: rst, start: st, addr: addr, ins: ins, br: br, z: z,
             h: h, s: s, exp: e};
  endfunction

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic apply(input vec_t t);
    reset       = t.rst;
    start       = t.start;
    start_addr  = t.addr;
    instruction = t.ins;
    branch      = t.br;
    zero        = t.z;
    halt_instr  = t.h;
    stall       = t.s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t t[3];
    out_t got;
    t[0] = v(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    t[1] = v(1, 1, 32'h55, 0, 1, 1, 1, 1, ex(0, 0, 0, 0, 0, 0));
    t[2] = v(0, 0, 32'h55, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      apply(t[i]);
      got = observed();
      vectors++;
      if (got !== t[i].exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b, want pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b",
                 i, got.pc, got.ic, got.tc, got.fe, got.dn, got.bt,
                 t[i].exp.pc, t[i].exp.ic, t[i].exp.tc, t[i].exp.fe, t[i].exp.dn, t[i].exp.bt);
      end
    end
  endtask

  task automatic test_sequential();
    vec_t t[4];
    out_t got;
    t[0] = v(0, 1, 32'h100, 0, 0, 0, 0, 0, ex(32'h100, 0, 0, 1, 0, 0));
    t[1] = v(0, 0, 32'h0,   0, 0, 0, 0, 0, ex(32'h104, 1, 0, 1, 0, 0));
    t[2] = v(0, 0, 32'h0,   0, 0, 0, 0, 0, ex(32'h108, 2, 0, 1, 0, 0));
    t[3] = v(0, 0, 32'h0,   0, 0, 0, 0, 0, ex(32'h10C, 3, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      apply(t[i]);
      got = observed();
      vectors++;
      if (got !== t[i].exp) begin
        miscompares++;
        $display("FAIL sequential[%0d]: got pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b, want pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b",
                 i, got.pc, got.ic, got.tc, got.fe, got.dn, got.bt,
                 t[i].exp.pc, t[i].exp.ic, t[i].exp.tc, t[i].exp.fe, t[i].exp.dn, t[i].exp.bt);
      end
    end
  endtask

  // Offsets: 0x1FF -> -1 (upper bits ignored), 0x03F -> +63, 0x040 -> -64.
  task automatic test_branch();
    vec_t t[7];
    out_t got;
    t[0] = v(0, 0, 0,       0,      0, 0, 1, 0, ex(32'h10C, 4, 0, 0, 1, 0));
    t[1] = v(0, 1, 32'h200, 0,      0, 0, 0, 0, ex(32'h200, 0, 0, 1, 0, 0));
    t[2] = v(0, 0, 0,       9'h1FF, 1, 1, 0, 0, ex(32'h200, 1, 1, 1, 0, 1));
    t[3] = v(0, 0, 0,       9'h1FF, 1, 0, 0, 0, ex(32'h204, 2, 1, 1, 0, 0));
    t[4] = v(0, 0, 0,       9'h03F, 1, 1, 0, 0, ex(32'h304, 3, 2, 1, 0, 1));
    t[5] = v(0, 0, 0,       9'h040, 1, 1, 0, 0, ex(32'h208, 4, 3, 1, 0, 1));
    t[6] = v(0, 0, 0,       9'h040, 0, 1, 0, 0, ex(32'h20C, 5, 3, 1, 0, 0));
    for (int i = 0; i < 7; i++) begin
      apply(t[i]);
      got = observed();
      vectors++;
      if (got !== t[i].exp) begin
        miscompares++;
        $display("FAIL branch[%0d]: got pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b, want pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b",
                 i, got.pc, got.ic, got.tc, got.fe, got.dn, got.bt,
                 t[i].exp.pc, t[i].exp.ic, t[i].exp.tc, t[i].exp.fe, t[i].exp.dn, t[i].exp.bt);
      end
    end
  endtask

  // Branch at 0x40 with offset +4 words -> 0x44 + 0x10 = 0x54, taken once after the stall.
  task automatic test_stall();
    vec_t t[8];
    out_t got;
    t[0] = v(0, 0, 0,      0,      0, 0, 1, 0, ex(32'h20C, 6, 3, 0, 1, 0));
    t[1] = v(0, 1, 32'h40, 0,      0, 0, 0, 0, ex(32'h40,  0, 0, 1, 0, 0));
    t[2] = v(0, 0, 0,      9'h004, 1, 1, 0, 1, ex(32'h40,  0, 0, 0, 0, 0));
    t[3] = v(0, 0, 0,      9'h004, 1, 1, 0, 1, ex(32'h40,  0, 0, 0, 0, 0));
    t[4] = v(0, 0, 0,      9'h004, 1, 1, 0, 1, ex(32'h40,  0, 0, 0, 0, 0));
    t[5] = v(0, 0, 0,      9'h004, 1, 1, 0, 0, ex(32'h40,  0, 0, 1, 0, 0));
    t[6] = v(0, 0, 0,      9'h004, 1, 1, 0, 0, ex(32'h54,  1, 1, 1, 0, 1));
    t[7] = v(0, 0, 0,      0,      0, 0, 0, 0, ex(32'h58,  2, 1, 1, 0, 0));
    for (int i = 0; i < 8; i++) begin
      apply(t[i]);
      got = observed();
      vectors++;
      if (got !== t[i].exp) begin
        miscompares++;
        $display("FAIL stall[%0d]: got pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b, want pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b",
                 i, got.pc, got.ic, got.tc, got.fe, got.dn, got.bt,
                 t[i].exp.pc, t[i].exp.ic, t[i].exp.tc, t[i].exp.fe, t[i].exp.dn, t[i].exp.bt);
      end
    end
  endtask

  // Priority checks: stall beats halt, halt beats a taken branch.
  task automatic test_halt();
    vec_t t[7];
    out_t got;
    t[0] = v(0, 0, 0,      0,      0, 0, 1, 0, ex(32'h58, 3, 1, 0, 1, 0));
    t[1] = v(0, 1, 32'h80, 0,      0, 0, 0, 0, ex(32'h80, 0, 0, 1, 0, 0));
    t[2] = v(0, 0, 0,      9'h004, 1, 1, 1, 1, ex(32'h80, 0, 0, 0, 0, 0));
    t[3] = v(0, 0, 0,      9'h004, 1, 1, 1, 0, ex(32'h80, 0, 0, 1, 0, 0));
    t[4] = v(0, 0, 0,      9'h004, 1, 1, 1, 0, ex(32'h80, 1, 0, 0, 1, 0));
    t[5] = v(0, 0, 0,      0,      0, 0, 0, 0, ex(32'h80, 1, 0, 0, 1, 0));
    t[6] = v(0, 1, 32'h0,  0,      0, 0, 0, 0, ex(32'h0,  0, 0, 1, 0, 0));
    for (int i = 0; i < 7; i++) begin
      apply(t[i]);
      got = observed();
      vectors++;
      if (got !== t[i].exp) begin
        miscompares++;
        $display("FAIL halt[%0d]: got pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b, want pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b",
                 i, got.pc, got.ic, got.tc, got.fe, got.dn, got.bt,
                 t[i].exp.pc, t[i].exp.ic, t[i].exp.tc, t[i].exp.fe, t[i].exp.dn, t[i].exp.bt);
      end
    end
  endtask

  task automatic test_wrap_and_start_ignored();
    vec_t t[5];
    out_t got;
    t[0] = v(0, 0, 0,            0, 0, 0, 1, 0, ex(32'h0,        1, 0, 0, 1, 0));
    t[1] = v(0, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, ex(32'hFFFFFFFC, 0, 0, 1, 0, 0));
    t[2] = v(0, 0, 0,            0, 0, 0, 0, 0, ex(32'h0,        1, 0, 1, 0, 0));
    t[3] = v(0, 1, 32'h500,      0, 0, 0, 0, 0, ex(32'h4,        2, 0, 1, 0, 0));
    t[4] = v(0, 1, 32'h500,      0, 0, 0, 0, 1, ex(32'h4,        2, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      apply(t[i]);
      got = observed();
      vectors++;
      if (got !== t[i].exp) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b, want pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b",
                 i, got.pc, got.ic, got.tc, got.fe, got.dn, got.bt,
                 t[i].exp.pc, t[i].exp.ic, t[i].exp.tc, t[i].exp.fe, t[i].exp.dn, t[i].exp.bt);
      end
    end
  endtask

  // Entered from STALL; reset must win over start/stall on the same edge.
  task automatic test_reset_in_stall();
    vec_t t[2];
    out_t got;
    t[0] = v(1, 1, 32'h500, 9'h004, 1, 1, 1, 1, ex(0, 0, 0, 0, 0, 0));
    t[1] = v(0, 0, 0,       0,      0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      apply(t[i]);
      got = observed();
      vectors++;
      if (got !== t[i].exp) begin
        miscompares++;
        $display("FAIL reset_in_stall[%0d]: got pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b, want pc=%h ic=%0d tc=%0d fe=%b dn=%b bt=%b",
                 i, got.pc, got.ic, got.tc, got.fe, got.dn, got.bt,
                 t[i].exp.pc, t[i].exp.ic, t[i].exp.tc, t[i].exp.fe, t[i].exp.dn, t[i].exp.bt);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    start_addr  = '0;
    instruction = '0;
    branch      = 1'b0;
    zero        = 1'b0;
    halt_instr  = 1'b0;
    stall       = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_wrap_and_start_ignored();
    test_reset_in_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
